// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, PC reset value and
// instruction-bus bundles for later interface grouping.
package if_fetch_ctrl_pkg;

  localparam logic [31:0] PC_RESET = 32'hBFC0_0000;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StWait    = 3'd2,
    StHold    = 3'd3,
    StDiscard = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
  } inst_bus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } inst_bus_rsp_t;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction fetch controller: issues one SRAM-like bus request per PC, hands the
// result to decode, and drops responses that belong to a flushed fetch.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32,
  parameter logic [ADDR_W-1:0] RST_PC = ADDR_W'(PC_RESET)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic              flush_i,
  input  logic              id_allow_i,
  output logic              pc_wr_o,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [DATA_W-1:0] inst_rdata_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              adel_o
);

  fetch_state_e      state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              adel_q, adel_d;

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    adel_d  = adel_q;
    unique case (state_q)
      StIdle: begin
        if (pc_valid_i && !flush_i) begin
          if (pc_misaligned(pc_i[1:0])) begin
            // Faulting PC goes straight to decode without touching the bus.
            pc_d    = pc_i;
            inst_d  = '0;
            adel_d  = 1'b1;
            state_d = StHold;
          end else begin
            addr_d  = pc_i;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // The request cannot be withdrawn, so a flush here only marks it stale.
        if (inst_addr_ok_i) begin
          state_d = (drop_q || flush_i) ? StDiscard : StWait;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      StWait: begin
        if (inst_data_ok_i) begin
          if (flush_i) begin
            state_d = StIdle;
          end else begin
            inst_d  = inst_rdata_i;
            pc_d    = addr_q;
            adel_d  = 1'b0;
            state_d = StHold;
          end
        end else if (flush_i) begin
          state_d = StDiscard;
        end
      end
      StHold: begin
        if (flush_i || id_allow_i) begin
          state_d = StIdle;
        end
      end
      StDiscard: begin
        if (inst_data_ok_i) begin
          drop_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      pc_q    <= RST_PC;
      inst_q  <= '0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      adel_q  <= adel_d;
    end
  end

  assign inst_req_o   = (state_q == StReq);
  assign inst_addr_o  = addr_q;
  assign inst_valid_o = (state_q == StHold);
  assign inst_o       = inst_q;
  assign inst_pc_o    = pc_q;
  assign adel_o       = adel_q;
  assign pc_wr_o      = flush_i | ((state_q == StHold) & id_allow_i);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: bus responder with programmable wait states and a
// scoreboard of expected decode handoffs.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i, flush_i, id_allow_i;
  logic        pc_wr_o, inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i, inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o, inst_pc_o;
  logic        adel_o;

  if_fetch_ctrl #(
    .ADDR_W(32),
    .DATA_W(32),
    .RST_PC(RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .flush_i       (flush_i),
    .id_allow_i    (id_allow_i),
    .pc_wr_o       (pc_wr_o),
    .inst_req_o    (inst_req_o),
    .inst_addr_o   (inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i),
    .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i  (inst_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .adel_o        (adel_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int handoffs = 0, pc_wr_cnt = 0, req_cnt = 0;

  // Bus responder state.
  int addr_dly = 0, data_dly = 0, acnt = 0, dcnt = 0;
  logic busy = 1'b0, bad_data = 1'b0;
  logic [31:0] req_addr, bus_addr;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mem(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'h1234_5678);
  endfunction

  // One clock cycle; entered and left at posedge+1.
  task automatic step();
    exp_t e;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b0;
    inst_rdata_i   = '0;
    if (busy) begin
      if (dcnt == data_dly) begin
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = bad_data ? 32'hDEAD_BEEF : model_mem(bus_addr);
      end
    end else if (inst_req_o) begin
      if (acnt == 0) req_addr = inst_addr_o;
      else check_val("addr_stable", inst_addr_o, req_addr);
      if (acnt == addr_dly) inst_addr_ok_i = 1'b1;
    end
    #4;
    if (pc_wr_o) pc_wr_cnt++;
    if (inst_req_o) req_cnt++;
    if (inst_valid_o) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", inst_valid_o, 1'b0);
      end else begin
        e = sb[0];
        check_val("inst", inst_o, e.inst);
        check_val("inst_pc", inst_pc_o, e.pc);
        check_val("adel", adel_o, e.adel);
        if (id_allow_i) begin
          void'(sb.pop_front());
          handoffs++;
        end
      end
    end
    @(posedge clk);
    if (rst) begin
      busy = 1'b0;
      acnt = 0;
    end else if (busy) begin
      if (inst_data_ok_i) busy = 1'b0;
      else dcnt++;
    end else if (inst_addr_ok_i) begin
      busy     = 1'b1;
      dcnt     = 0;
      acnt     = 0;
      bus_addr = req_addr;
    end else if (inst_req_o) begin
      acnt++;
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input int adly, input int ddly, input int hold,
                       input int exp_lat);
    int h0, w0, r0, n, hold_left;
    exp_t e;
    addr_dly  = adly;
    data_dly  = ddly;
    bad_data  = 1'b0;
    hold_left = hold;
    h0 = handoffs; w0 = pc_wr_cnt; r0 = req_cnt;
    e.adel = (pc[1:0] != 2'b00);
    e.pc   = pc;
    e.inst = e.adel ? 32'h0 : model_mem(pc);
    sb.push_back(e);
    pc_i = pc; pc_valid_i = 1'b1; id_allow_i = 1'b1;
    step();
    pc_valid_i = 1'b0;
    n = 0;
    while (handoffs == h0 && n < 40) begin
      id_allow_i = 1'b1;
      if (inst_valid_o && hold_left > 0) begin
        id_allow_i = 1'b0;
        hold_left--;
      end
      step();
      n++;
    end
    id_allow_i = 1'b1;
    check_val("handoff_count", handoffs - h0, 1);
    check_val("latency", n, exp_lat);
    check_val("pc_wr_pulses", pc_wr_cnt - w0, 1);
    check_val("req_cycles", req_cnt - r0, e.adel ? 0 : adly + 1);
  endtask

  initial begin
    int w0, r0;
    rst = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; id_allow_i = 1'b1;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    check_val("rst_req", inst_req_o, 1'b0);
    check_val("rst_addr", inst_addr_o, 32'h0);
    check_val("rst_valid", inst_valid_o, 1'b0);
    check_val("rst_inst", inst_o, 32'h0);
    check_val("rst_inst_pc", inst_pc_o, RST_PC);
    check_val("rst_adel", adel_o, 1'b0);
    check_val("rst_pc_wr", pc_wr_o, 1'b0);

    // Zero-wait, decode backpressure, bus wait states.
    fetch(32'hBFC0_0000, 0, 0, 0, 3);
    fetch(32'hBFC0_0004, 0, 0, 5, 8);
    fetch(32'hBFC0_0008, 3, 4, 0, 10);

    // Flush while WAIT; stale DEAD_BEEF response must be swallowed.
    w0 = pc_wr_cnt;
    addr_dly = 0; data_dly = 2;
    pc_i = 32'h8000_0100; pc_valid_i = 1'b1; step();
    pc_valid_i = 1'b0; bad_data = 1'b1; step();
    flush_i = 1'b1; step();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_val("flush_wait_pc_wr", pc_wr_cnt - w0, 1);
    check_val("flush_wait_idle_req", inst_req_o, 1'b0);
    fetch(32'h8000_0180, 0, 0, 0, 3);

    // Flush during REQ before addr_ok.
    w0 = pc_wr_cnt; r0 = req_cnt;
    addr_dly = 2; data_dly = 0;
    pc_i = 32'h8000_0200; pc_valid_i = 1'b1; step();
    pc_valid_i = 1'b0; bad_data = 1'b1; flush_i = 1'b1; step();
    flush_i = 1'b0;
    check_val("flush_req_held", inst_req_o, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check_val("flush_req_cycles", req_cnt - r0, 3);
    check_val("flush_req_pc_wr", pc_wr_cnt - w0, 1);
    check_val("flush_req_busy", busy, 1'b0);

    // Flush coincident with data_ok in WAIT.
    addr_dly = 0; data_dly = 0;
    pc_i = 32'h8000_0300; pc_valid_i = 1'b1; step();
    pc_valid_i = 1'b0; bad_data = 1'b1; step();
    flush_i = 1'b1; step();
    flush_i = 1'b0;
    check_val("flush_data_valid", inst_valid_o, 1'b0);
    check_val("flush_data_req", inst_req_o, 1'b0);
    step(); step();
    fetch(32'h8000_0304, 1, 1, 0, 5);

    // Misaligned PC: address error without a bus request.
    fetch(32'hBFC0_0002, 0, 0, 0, 1);
    fetch(32'hBFC0_0010, 0, 0, 0, 3);

    // Reset in WAIT.
    addr_dly = 0; data_dly = 3; bad_data = 1'b0;
    pc_i = 32'h8000_0400; pc_valid_i = 1'b1; step();
    pc_valid_i = 1'b0; step();
    rst = 1'b1; step();
    rst = 1'b0;
    check_val("wrst_req", inst_req_o, 1'b0);
    check_val("wrst_addr", inst_addr_o, 32'h0);
    check_val("wrst_valid", inst_valid_o, 1'b0);
    check_val("wrst_inst", inst_o, 32'h0);
    check_val("wrst_inst_pc", inst_pc_o, RST_PC);
    check_val("wrst_adel", adel_o, 1'b0);
    for (int i = 0; i < 5; i++) step();
    fetch(32'hBFC0_0000, 0, 0, 0, 3);

    check_val("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
